// File: rtl/rv32i_reg_file_scoreboard.sv
// ============================================================================
// rv32i_reg_file_scoreboard : 32x32 integer register file with a per-register
//                             pending-write scoreboard (issue marks, writeback retires)
// Rev 1.0
// ============================================================================
`default_nettype none

module rv32i_reg_file_scoreboard #(
  parameter int PEND_W = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [4:0]  i_rd_decode,
  input  logic        i_rden,
  input  logic [4:0]  i_rd,
  input  logic [31:0] i_w_data,
  input  logic        i_wen,
  input  logic        i_flush,
  output logic [31:0] o_rs1_data,
  output logic [31:0] o_rs2_data,
  output logic        o_rs1_busy,
  output logic        o_rs2_busy,
  output logic        o_rd_busy,
  output logic        o_clear_status
);

  localparam logic [PEND_W-1:0] C_MAX = '1;

  logic [31:0]       r_regs [32];
  logic [PEND_W-1:0] r_cnt  [32];
  logic              r_clear_status;

  logic              w_wr;
  logic [31:0]       w_inc;
  logic [31:0]       w_dec;
  logic [PEND_W-1:0] w_cnt_nxt [32];
  logic              w_clear;
  logic              w_dec_rs1;
  logic              w_dec_rs2;
  logic [PEND_W-1:0] w_left_rs1;
  logic [PEND_W-1:0] w_left_rs2;

  assign w_wr = i_wen && (i_rd != 5'd0);

  // Per-register issue/retire qualifiers; x0 never counts.
  for (genvar r = 0; r < 32; r++) begin : g_slot
    assign w_inc[r] = (r != 0) && i_rden && (i_rd_decode == 5'(r)) && (r_cnt[r] != C_MAX);
    assign w_dec[r] = (r != 0) && i_wen  && (i_rd == 5'(r))        && (r_cnt[r] != '0);
  end

  always_comb begin
    w_clear = 1'b0;
    for (int r = 0; r < 32; r++) begin
      w_cnt_nxt[r] = r_cnt[r];
      if (i_flush) begin
        w_cnt_nxt[r] = '0;
      end else if (w_inc[r] && !w_dec[r]) begin
        w_cnt_nxt[r] = r_cnt[r] + PEND_W'(1);
      end else if (w_dec[r] && !w_inc[r]) begin
        w_cnt_nxt[r] = r_cnt[r] - PEND_W'(1);
        if (r_cnt[r] == PEND_W'(1)) w_clear = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int r = 0; r < 32; r++) begin
        r_regs[r] <= '0;
        r_cnt[r]  <= '0;
      end
      r_clear_status <= 1'b0;
    end else begin
      if (w_wr) r_regs[i_rd] <= i_w_data;
      for (int r = 0; r < 32; r++) r_cnt[r] <= w_cnt_nxt[r];
      r_clear_status <= w_clear;
    end
  end

  // Busy reflects the count after this cycle's retire, matching the write-first bypass.
  assign w_dec_rs1  = w_wr && (i_rd == i_rs1) && (r_cnt[i_rs1] != '0);
  assign w_dec_rs2  = w_wr && (i_rd == i_rs2) && (r_cnt[i_rs2] != '0);
  assign w_left_rs1 = r_cnt[i_rs1] - PEND_W'(w_dec_rs1);
  assign w_left_rs2 = r_cnt[i_rs2] - PEND_W'(w_dec_rs2);

  assign o_rs1_data = (i_rs1 == 5'd0) ? 32'd0 :
                      (w_wr && (i_rd == i_rs1)) ? i_w_data : r_regs[i_rs1];
  assign o_rs2_data = (i_rs2 == 5'd0) ? 32'd0 :
                      (w_wr && (i_rd == i_rs2)) ? i_w_data : r_regs[i_rs2];

  assign o_rs1_busy     = (i_rs1 != 5'd0) && (w_left_rs1 != '0);
  assign o_rs2_busy     = (i_rs2 != 5'd0) && (w_left_rs2 != '0);
  assign o_rd_busy      = (i_rd_decode != 5'd0) && (r_cnt[i_rd_decode] == C_MAX);
  assign o_clear_status = r_clear_status;

endmodule

`default_nettype wire
